// File: rtl/screen_snoop_if.sv
// rtl/screen_snoop_if.sv - Z80 write bus and dual screen write-port bundle for screen_snoop
interface screen_snoop_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_mreq_n;
  logic        cpu_iorq_n;
  logic        cpu_wr_n;
  logic        cpu_m1_n;
  logic [7:0]  scr_write;
  logic [12:0] scr_write_addr;
  logic        scr_write_we;
  logic [7:0]  scr_write2;
  logic [12:0] scr_write_addr2;
  logic        scr_write_we2;
  logic [2:0]  border;
  logic        screen_flip;
  logic        clear_busy;

  modport slave (
    input  cpu_addr, cpu_dout, cpu_mreq_n, cpu_iorq_n, cpu_wr_n, cpu_m1_n,
    output scr_write, scr_write_addr, scr_write_we,
    output scr_write2, scr_write_addr2, scr_write_we2,
    output border, screen_flip, clear_busy
  );

  modport master (
    output cpu_addr, cpu_dout, cpu_mreq_n, cpu_iorq_n, cpu_wr_n, cpu_m1_n,
    input  scr_write, scr_write_addr, scr_write_we,
    input  scr_write2, scr_write_addr2, scr_write_we2,
    input  border, screen_flip, clear_busy
  );
endinterface

// File: rtl/screen_snoop.sv
// rtl/screen_snoop.sv - Z80 write snooper feeding the dual Spectrum screen buffers
// Define SCREEN_CLEAR_EN to build the post-reset buffer clear sequencer.
module screen_snoop #(
  parameter int          MODEL128  = 1,
  parameter logic [7:0]  ATTR_INIT = 8'h38
) (
  input  logic          sys_clk,
  input  logic          rst,
  screen_snoop_if.slave bus
);
  localparam logic L_M128 = (MODEL128 != 0);

  logic        r_mem_strb_q;
  logic        r_io_strb_q;
  logic [2:0]  r_ram_bank;
  logic        r_flip;
  logic        r_lock;
  logic [2:0]  r_border;
  logic [7:0]  r_data1;
  logic [12:0] r_addr1;
  logic        r_we1;
  logic [7:0]  r_data2;
  logic [12:0] r_addr2;
  logic        r_we2;

  logic        w_mem_strb;
  logic        w_io_strb;
  logic        w_mem_ev;
  logic        w_io_ev;
  logic [13:0] w_off;
  logic        w_in_scr;
  logic        w_hit1;
  logic        w_hit2;
  logic        w_page_wr;
  logic        w_border_wr;

  // Events fire on the first sampled low of a strobe after a sampled high.
  assign w_mem_strb  = bus.cpu_mreq_n | bus.cpu_wr_n;
  assign w_io_strb   = bus.cpu_iorq_n | bus.cpu_wr_n;
  assign w_mem_ev    = ~w_mem_strb & r_mem_strb_q;
  assign w_io_ev     = ~w_io_strb & r_io_strb_q & bus.cpu_m1_n;
  assign w_off       = bus.cpu_addr[13:0];
  assign w_in_scr    = (w_off <= 14'h1AFF);
  assign w_hit1      = w_mem_ev & w_in_scr &
                       ((bus.cpu_addr[15:14] == 2'b01) |
                        ((bus.cpu_addr[15:14] == 2'b11) & (r_ram_bank == 3'd5)));
  assign w_hit2      = w_mem_ev & w_in_scr & L_M128 &
                       (bus.cpu_addr[15:14] == 2'b11) & (r_ram_bank == 3'd7);
  assign w_page_wr   = w_io_ev & ~bus.cpu_addr[15] & ~bus.cpu_addr[1] & L_M128 & ~r_lock;
  assign w_border_wr = w_io_ev & ~bus.cpu_addr[0];

`ifdef SCREEN_CLEAR_EN
  typedef enum logic {S_CLEAR, S_DONE} state_t;
  state_t      r_state;
  logic [12:0] r_cnt;
  logic        r_busy;
  logic [7:0]  w_clr_data;

  assign w_clr_data     = (r_cnt < 13'h1800) ? 8'h00 : ATTR_INIT;
  assign bus.clear_busy = r_busy;
`else
  assign bus.clear_busy = 1'b0;
`endif

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_mem_strb_q <= 1'b1;
      r_io_strb_q  <= 1'b1;
      r_ram_bank   <= 3'd0;
      r_flip       <= 1'b0;
      r_lock       <= 1'b0;
      r_border     <= 3'd0;
      r_data1      <= 8'h00;
      r_addr1      <= 13'd0;
      r_we1        <= 1'b0;
      r_data2      <= 8'h00;
      r_addr2      <= 13'd0;
      r_we2        <= 1'b0;
`ifdef SCREEN_CLEAR_EN
      r_state      <= S_CLEAR;
      r_cnt        <= 13'd0;
      r_busy       <= 1'b1;
`endif
    end else begin
      r_mem_strb_q <= w_mem_strb;
      r_io_strb_q  <= w_io_strb;
      if (w_page_wr) begin
        r_ram_bank <= bus.cpu_dout[2:0];
        r_flip     <= bus.cpu_dout[3];
        r_lock     <= bus.cpu_dout[5];
      end
      if (w_border_wr) begin
        r_border <= bus.cpu_dout[2:0];
      end
      r_we1 <= 1'b0;
      r_we2 <= 1'b0;
      if (w_hit1) begin
        r_we1   <= 1'b1;
        r_addr1 <= w_off[12:0];
        r_data1 <= bus.cpu_dout;
      end
      if (w_hit2) begin
        r_we2   <= 1'b1;
        r_addr2 <= w_off[12:0];
        r_data2 <= bus.cpu_dout;
      end
`ifdef SCREEN_CLEAR_EN
      // A CPU hit owns the write ports this cycle; the counter simply waits.
      if ((r_state == S_CLEAR) && !(w_hit1 | w_hit2)) begin
        r_we1   <= 1'b1;
        r_addr1 <= r_cnt;
        r_data1 <= w_clr_data;
        if (L_M128) begin
          r_we2   <= 1'b1;
          r_addr2 <= r_cnt;
          r_data2 <= w_clr_data;
        end
        if (r_cnt == 13'h1AFF) begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
        end else begin
          r_cnt <= r_cnt + 13'd1;
        end
      end
`endif
    end
  end

  assign bus.scr_write       = r_data1;
  assign bus.scr_write_addr  = r_addr1;
  assign bus.scr_write_we    = r_we1;
  assign bus.scr_write2      = r_data2;
  assign bus.scr_write_addr2 = r_addr2;
  assign bus.scr_write_we2   = r_we2;
  assign bus.border          = r_border;
  assign bus.screen_flip     = r_flip;
endmodule

// File: doc/screen_snoop.md
# screen_snoop

Bus-side writer for the dual Spectrum screen buffers. Samples Z80 memory and I/O writes in the `sys_clk` domain and tracks the 128K paging and border latches. Emits the single-cycle write-port traffic consumed by the display block: `scr_write*`, `scr_write*2`, `border` and `screen_flip`. An optional post-reset sequencer clears both screen buffers.

## Interface
Parameters:
- `MODEL128`, default 1: 1 enables port 0x7FFD paging and screen 2; 0 means 48K only.
- `ATTR_INIT`, default 8'h38: attribute byte written by the clear sequencer.

Ports:
- `sys_clk`  in  1  sole clock; all bus inputs are synchronous to it.
- `rst`  in  1  asynchronous, active-high reset.
- `cpu_addr`  in  16  Z80 address bus.
- `cpu_dout`  in  8  Z80 write data.
- `cpu_mreq_n`  in  1  memory request, active low.
- `cpu_iorq_n`  in  1  I/O request, active low.
- `cpu_wr_n`  in  1  write strobe, active low.
- `cpu_m1_n`  in  1  M1, active low; I/O with M1 low is an interrupt acknowledge and is ignored.
- `scr_write`  out  8  screen 1 write data.
- `scr_write_addr`  out  13  screen 1 byte offset, 0x0000–0x1AFF.
- `scr_write_we`  out  1  screen 1 write enable, one-cycle pulse.
- `scr_write2`  out  8  screen 2 write data.
- `scr_write_addr2`  out  13  screen 2 byte offset.
- `scr_write_we2`  out  1  screen 2 write enable, one-cycle pulse.
- `border`  out  3  border colour.
- `screen_flip`  out  1  0 selects screen 1 (bank 5), 1 selects screen 2 (bank 7).
- `clear_busy`  out  1  high while the clear sequencer runs.

## Operation
- **Write event.**
  - Memory write event: first `sys_clk` edge where `cpu_mreq_n|cpu_wr_n` samples 0, after having sampled 1 on the previous edge.
  - I/O write event: same rule using `cpu_iorq_n|cpu_wr_n`, additionally requiring `cpu_m1_n`=1.
  - A strobe held low for many cycles produces exactly one event.
- **Paging register.**
  - 3-bit `ram_bank`, `flip`, and `lock`. All are 0 at reset.
  - An I/O write with A15=0 and A1=0, when `MODEL128`=1 and `lock`=0, loads `ram_bank`=D[2:0], `flip`=D[3], `lock`=D[5].
  - Once `lock`=1, further 0x7FFD writes are ignored until `rst`.
- **Border.** An I/O write with A0=0 loads `border`=D[2:0]. A single access matching both decodes updates both registers.
- **Screen 1 hits** (memory write, offset = A & 0x3FFF, offset ≤ 0x1AFF):
  - A[15:14]=01.
  - A[15:14]=11 with `ram_bank`=5.
- **Screen 2 hit:** A[15:14]=11 with `ram_bank`=7, `MODEL128`=1, offset ≤ 0x1AFF.
- **Non-hits:** offsets 0x1B00–0x3FFF, and any write outside these windows, produce no pulse.
- **Paging decision:** uses the `ram_bank` value in effect at the memory write event, not a 0x7FFD write arriving later.
- **Output values:**
  - `scr_write*`/`scr_write_addr*` hold their last value when not strobed.
  - `screen_flip` = `flip`.
- **Clear sequencer** (see Configuration). States:
  - CLEAR: entered on `rst` deassertion, 13-bit counter `cnt`=0.
  - DONE: terminal state.
- **Behaviour in CLEAR:**
  - Each cycle with no CPU screen hit: pulse both `scr_write_we` and `scr_write_we2` (screen 2 only if `MODEL128`=1) at `addr`=`cnt`.
  - Data is 0x00 for `cnt`<0x1800, else `ATTR_INIT`; then `cnt`++.
  - On a CPU screen hit cycle, the CPU write is issued and `cnt` holds; nothing is lost or duplicated.
  - After issuing `cnt`=0x1AFF, go to DONE.
  - `clear_busy`=1 exactly in CLEAR.
- **Reset mid-clear:** restarts from `cnt`=0.

## Timing
- **Reset values:**
  - `scr_write*`=0, `scr_write_addr*`=0, `scr_write_we*`=0, `border`=0, `screen_flip`=0.
  - `clear_busy`=1 with macro, 0 without.
- **Latency:** event detected on edge N; write enables/data/addr, `border` and `screen_flip` are registered and valid from edge N+1.
- **Pulse width:** write enables are high for exactly one cycle per event.
- **Back-to-back events:** one cycle apart are legal; the strobe must be high ≥1 sampled cycle between them.
- **Clear duration:** 0x1B00 = 6912 cycles plus one per intervening CPU screen hit.

## Configuration
- `SCREEN_CLEAR_EN` defined: the clear sequencer is built. Both buffers are initialised to bitmap 0x00 / attribute `ATTR_INIT` after every reset.
- Not defined: no sequencer is built, `clear_busy` is tied 0, and only CPU writes reach the buffers.

## Test plan
- **Screen 1 write.** Memory write A=0x4000 D=0xAA, strobe low 3 cycles -> one `scr_write_we` pulse one cycle later, addr=0x0000, data=0xAA; `scr_write_we2` stays 0.
- **Paged windows.**
  - OUT 0x7FFD,0x07 then write A=0xC005 D=0x11 -> `scr_write_we2` pulse, addr=0x0005, data=0x11.
  - OUT 0x7FFD,0x05 then write A=0xDAFF -> screen 1 addr=0x1AFF.
  - Write A=0xDB00 -> no pulse.
- **Flip, lock, border.**
  - OUT 0x7FFD,0x28 -> `screen_flip`=1, lock set.
  - OUT 0x7FFD,0x00 -> `screen_flip` stays 1.
  - OUT 0x00FE,0x05 -> `border`=5.
  - `rst` -> all 0.
- **Ignored I/O:** interrupt-acknowledge cycle (`cpu_m1_n`=0, `cpu_iorq_n`=0) with A=0x00FE -> `border` unchanged.
- **Clear sequence** (`SCREEN_CLEAR_EN`): after reset, 6912 pulses on each screen, addr 0x17FF data 0x00, addr 0x1800 data 0x38, `clear_busy` falls after addr 0x1AFF.
  - A CPU write to 0x4100 injected mid-clear is issued intact, and the sequence resumes at the held `cnt`.
- **Reset mid-clear:** assert `rst` at `cnt`=0x0800 -> outputs return to reset values; after release the sequencer restarts at addr 0x0000.
